// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the two-master native-memory-interface arbiter:
// default widths, FSM state encoding and a strobe-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 255;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StGnt0 = ST_GNT0,
        StGnt1 = ST_GNT1
    } state_e;

    // Byte-strobe width for a given data width.
    function automatic int unsigned strb_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
// Native memory interface bundle (valid/ready with instr/addr/wdata/wstrb/rdata).
// Signals:
//   valid  requester -> responder  request, held until ready
//   instr  requester -> responder  instruction-fetch flag
//   addr   requester -> responder  ADDR_W address
//   wdata  requester -> responder  DATA_W write data
//   wstrb  requester -> responder  DATA_W/8 byte strobes, 0 means read
//   ready  responder -> requester  transaction done
//   rdata  responder -> requester  DATA_W read data
// Modports: master (requester side), slave (responder side).
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic                        valid;
    logic                        instr;
    logic [ADDR_W-1:0]           addr;
    logic [DATA_W-1:0]           wdata;
    logic [strb_w(DATA_W)-1:0]   wstrb;
    logic                        ready;
    logic [DATA_W-1:0]           rdata;

    modport master (
        output valid,
        output instr,
        output addr,
        output wdata,
        output wstrb,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  instr,
        input  addr,
        input  wdata,
        input  wstrb,
        output ready,
        output rdata
    );

endinterface

// File: rtl/mem_bus_rr_pick.sv
// -----------------------------------------------------------------------------
// mem_bus_rr_pick
// Combinational two-input round-robin selector.
// Ports:
//   i_valid[1:0]  request lines of master 1 and master 0
//   i_last        index of the master granted most recently
//   o_grant       index of the master to grant (valid only when o_any)
//   o_any         at least one request present
// -----------------------------------------------------------------------------
module mem_bus_rr_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic       o_grant,
    output logic       o_any
);

    always_comb begin
        o_any = |i_valid;
        // On a tie the master that was not served last wins.
        if (&i_valid) begin
            o_grant = ~i_last;
        end else begin
            o_grant = i_valid[1];
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one native-memory slave port between two masters with round-robin
// arbitration. A grant is held for the whole transaction; every transaction
// is followed by one idle arbitration cycle.
// Ports:
//   i_clk    clock
//   i_reset  synchronous active-high reset
//   m0, m1   master ports (slave modport: arbiter responds to the masters)
//   s        shared slave port (master modport: arbiter requests)
//   o_err    one-cycle timeout pulse; tied 0 unless MEM_BUS_ARBITER_TIMEOUT_EN
// Build option:
//   MEM_BUS_ARBITER_TIMEOUT_EN  abort a transaction after TIMEOUT cycles
//                               without s.ready, answering the master with
//                               ready=1, rdata=0 and pulsing o_err.
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                i_clk,
    input  logic                i_reset,
    mem_bus_arbiter_if.slave    m0,
    mem_bus_arbiter_if.slave    m1,
    mem_bus_arbiter_if.master   s,
    output logic                o_err
);

    localparam int unsigned STRB_W = strb_w(DATA_W);

    state_e r_state;
    state_e w_state_nxt;
    logic   r_last;
    logic   w_last_nxt;

    logic   w_pick;
    logic   w_any;
    logic   w_gnt;       // in a grant state
    logic   w_sel1;      // master 1 is the granted master
    logic   w_active;    // grant state and not being reset
    logic   w_req;       // granted master's valid
    logic   w_done;      // granted transaction completes normally
    logic   w_tmo;       // granted transaction is aborted this cycle
    logic   w_fwd_ready;

    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [STRB_W-1:0] w_wstrb;
    logic              w_instr;

    mem_bus_rr_pick u_pick (
        .i_valid ({m1.valid, m0.valid}),
        .i_last  (r_last),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    assign w_gnt    = (r_state != StIdle);
    assign w_sel1   = (r_state == StGnt1);
    assign w_active = w_gnt && !i_reset;
    assign w_req    = w_sel1 ? m1.valid : m0.valid;
    assign w_done   = w_gnt && w_req && s.ready && !w_tmo;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] r_tmo_cnt;

    // Cleared while idle so each grant starts from zero; never passes
    // TIMEOUT because reaching it ends the grant.
    always_ff @(posedge i_clk) begin
        if (i_reset || !w_gnt) begin
            r_tmo_cnt <= '0;
        end else if (!s.ready) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo = w_gnt && w_req && (r_tmo_cnt == CNT_W'(TIMEOUT));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_tmo            = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_state_nxt = w_pick ? StGnt1 : StGnt0;
                end
            end
            StGnt0, StGnt1: begin
                if (!w_req) begin
                    // Master withdrew its request: abandon without
                    // touching the fairness history.
                    w_state_nxt = StIdle;
                end else if (w_done || w_tmo) begin
                    w_state_nxt = StIdle;
                    w_last_nxt  = w_sel1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Request mux from the granted master.
    always_comb begin
        if (w_sel1) begin
            w_instr = m1.instr;
            w_addr  = m1.addr;
            w_wdata = m1.wdata;
            w_wstrb = m1.wstrb;
        end else begin
            w_instr = m0.instr;
            w_addr  = m0.addr;
            w_wdata = m0.wdata;
            w_wstrb = m0.wstrb;
        end
    end

    // Bus outputs. Everything is gated by reset so an in-flight slave
    // response is never forwarded in the reset cycle.
    always_comb begin
        s.valid     = 1'b0;
        s.instr     = 1'b0;
        s.addr      = '0;
        s.wdata     = '0;
        s.wstrb     = '0;
        m0.ready    = 1'b0;
        m0.rdata    = '0;
        m1.ready    = 1'b0;
        m1.rdata    = '0;
        o_err       = 1'b0;
        w_fwd_ready = 1'b0;
        if (w_active) begin
            s.instr = w_instr;
            s.addr  = w_addr;
            s.wdata = w_wdata;
            s.wstrb = w_wstrb;
            if (w_tmo) begin
                s.valid     = 1'b0;
                o_err       = 1'b1;
                w_fwd_ready = 1'b1;
            end else begin
                s.valid     = w_req;
                w_fwd_ready = w_req && s.ready;
            end
            if (w_sel1) begin
                m1.ready = w_fwd_ready;
                m1.rdata = (w_fwd_ready && !w_tmo) ? s.rdata : '0;
            end else begin
                m0.ready = w_fwd_ready;
                m0.rdata = (w_fwd_ready && !w_tmo) ? s.rdata : '0;
            end
        end
    end

endmodule
